// File: rtl/sent_tx_frame_sched.sv
// SENT transmitter frame scheduler: sequences FIFO loads, frame start and frame done,
// tracks the slow-channel bit position and flags stale data and load timeouts.
module sent_tx_frame_sched #(
  parameter int unsigned LOAD_TIMEOUT = 255,
  parameter int unsigned SHORT_LEN    = 16,
  parameter int unsigned ENH_LEN      = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       channel_format,
  input  logic [1:0] f1_width,
  input  logic [1:0] f2_width,
  input  logic       f1_empty,
  input  logic       f2_empty,
  input  logic       done_f1,
  input  logic       done_f2,
  input  logic       frame_done,
  output logic       load_12bit_f1,
  output logic       load_14bit_f1,
  output logic       load_16bit_f1,
  output logic       load_8bit_f2,
  output logic       load_10bit_f2,
  output logic       load_12bit_f2,
  output logic       frame_start,
  output logic [4:0] serial_idx,
  output logic       msg_start,
  output logic       msg_done,
  output logic       stale_f1,
  output logic       stale_f2,
  output logic       load_err,
  output logic [7:0] underrun_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_LOAD  = 3'd2,
    ST_START      = 3'd3,
    ST_WAIT_FRAME = 3'd4
  } state_t;

  state_t     state_r;
  logic       pend_f1_r;
  logic       pend_f2_r;
  logic       fmt_r;
  logic [7:0] tmo_cnt_r;

  logic       pend_f1_s;
  logic       pend_f2_s;
  logic       timeout_s;
  logic       first_frame_s;
  logic       last_frame_s;
  logic [4:0] last_idx_s;
  logic [2:0] f1_sel_s;
  logic [2:0] f2_sel_s;
  logic [8:0] underrun_sum_s;
  logic [7:0] underrun_next_s;

  // Pending after this cycle's done pulses, width decode and saturating underrun sum
  always_comb begin
    pend_f1_s     = pend_f1_r & ~done_f1;
    pend_f2_s     = pend_f2_r & ~done_f2;
    timeout_s     = (tmo_cnt_r >= 8'(LOAD_TIMEOUT));
    last_idx_s    = fmt_r ? 5'(ENH_LEN - 32'd1) : 5'(SHORT_LEN - 32'd1);
    last_frame_s  = (serial_idx == last_idx_s);
    first_frame_s = (serial_idx == 5'd0);

    case (f1_width)
      2'd1:    f1_sel_s = 3'b010;
      2'd2:    f1_sel_s = 3'b100;
      default: f1_sel_s = 3'b001;
    endcase

    case (f2_width)
      2'd1:    f2_sel_s = 3'b010;
      2'd2:    f2_sel_s = 3'b100;
      default: f2_sel_s = 3'b001;
    endcase

    underrun_sum_s = {1'b0, underrun_cnt} + {8'd0, f1_empty} + {8'd0, f2_empty};
    if (underrun_sum_s[8]) begin
      underrun_next_s = 8'hFF;
    end else begin
      underrun_next_s = underrun_sum_s[7:0];
    end
  end

  // Scheduler state machine with all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      pend_f1_r     <= 1'b0;
      pend_f2_r     <= 1'b0;
      fmt_r         <= 1'b0;
      tmo_cnt_r     <= 8'd0;
      load_12bit_f1 <= 1'b0;
      load_14bit_f1 <= 1'b0;
      load_16bit_f1 <= 1'b0;
      load_8bit_f2  <= 1'b0;
      load_10bit_f2 <= 1'b0;
      load_12bit_f2 <= 1'b0;
      frame_start   <= 1'b0;
      serial_idx    <= 5'd0;
      msg_start     <= 1'b0;
      msg_done      <= 1'b0;
      stale_f1      <= 1'b0;
      stale_f2      <= 1'b0;
      load_err      <= 1'b0;
      underrun_cnt  <= 8'd0;
      busy          <= 1'b0;
    end else begin
      load_12bit_f1 <= 1'b0;
      load_14bit_f1 <= 1'b0;
      load_16bit_f1 <= 1'b0;
      load_8bit_f2  <= 1'b0;
      load_10bit_f2 <= 1'b0;
      load_12bit_f2 <= 1'b0;
      frame_start   <= 1'b0;
      msg_start     <= 1'b0;
      msg_done      <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          serial_idx <= 5'd0;
          if (enable) begin
            state_r <= ST_LOAD;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end

        ST_LOAD: begin
          {load_16bit_f1, load_14bit_f1, load_12bit_f1} <= f1_empty ? 3'b000 : f1_sel_s;
          {load_12bit_f2, load_10bit_f2, load_8bit_f2}  <= f2_empty ? 3'b000 : f2_sel_s;
          // A done seen in this very cycle already satisfies the load
          pend_f1_r    <= ~f1_empty & ~done_f1;
          pend_f2_r    <= ~f2_empty & ~done_f2;
          stale_f1     <= f1_empty;
          stale_f2     <= f2_empty;
          underrun_cnt <= underrun_next_s;
          tmo_cnt_r    <= 8'd0;
          state_r      <= ST_WAIT_LOAD;
        end

        ST_WAIT_LOAD: begin
          if ((pend_f1_s || pend_f2_s) && !timeout_s) begin
            pend_f1_r <= pend_f1_s;
            pend_f2_r <= pend_f2_s;
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end else begin
            if (pend_f1_s || pend_f2_s) begin
              load_err <= 1'b1;
            end
            if (pend_f1_s) begin
              stale_f1 <= 1'b1;
            end
            if (pend_f2_s) begin
              stale_f2 <= 1'b1;
            end
            pend_f1_r   <= 1'b0;
            pend_f2_r   <= 1'b0;
            tmo_cnt_r   <= 8'd0;
            frame_start <= 1'b1;
            state_r     <= ST_START;
            // Message format is captured only at the first frame of a message
            if (first_frame_s) begin
              msg_start <= 1'b1;
              fmt_r     <= channel_format;
            end
          end
        end

        ST_START: begin
          state_r <= ST_WAIT_FRAME;
        end

        ST_WAIT_FRAME: begin
          if (frame_done) begin
            msg_done <= last_frame_s;
            if (enable) begin
              serial_idx <= last_frame_s ? 5'd0 : serial_idx + 5'd1;
              state_r    <= ST_LOAD;
            end else begin
              serial_idx <= 5'd0;
              state_r    <= ST_IDLE;
              busy       <= 1'b0;
            end
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sent_tx_frame_sched.sv
// Self-checking bench for sent_tx_frame_sched: directed test-plan scenarios plus
// randomized frames against a frame-level reference model.
module tb_sent_tx_frame_sched;

  localparam int TMO   = 255;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       channel_format = 1'b0;
  logic [1:0] f1_width = 2'd0;
  logic [1:0] f2_width = 2'd0;
  logic       f1_empty = 1'b0;
  logic       f2_empty = 1'b0;
  logic       done_f1 = 1'b0;
  logic       done_f2 = 1'b0;
  logic       frame_done = 1'b0;
  logic       load_12bit_f1, load_14bit_f1, load_16bit_f1;
  logic       load_8bit_f2, load_10bit_f2, load_12bit_f2;
  logic       frame_start, msg_start, msg_done;
  logic [4:0] serial_idx;
  logic       stale_f1, stale_f2, load_err, busy;
  logic [7:0] underrun_cnt;
  logic [25:0] all_outs;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model state
  int exp_underrun = 0;
  int exp_idx      = 0;
  int exp_len      = 16;
  bit exp_err      = 1'b0;

  sent_tx_frame_sched dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .channel_format(channel_format),
    .f1_width(f1_width), .f2_width(f2_width), .f1_empty(f1_empty), .f2_empty(f2_empty),
    .done_f1(done_f1), .done_f2(done_f2), .frame_done(frame_done),
    .load_12bit_f1(load_12bit_f1), .load_14bit_f1(load_14bit_f1), .load_16bit_f1(load_16bit_f1),
    .load_8bit_f2(load_8bit_f2), .load_10bit_f2(load_10bit_f2), .load_12bit_f2(load_12bit_f2),
    .frame_start(frame_start), .serial_idx(serial_idx), .msg_start(msg_start),
    .msg_done(msg_done), .stale_f1(stale_f1), .stale_f2(stale_f2), .load_err(load_err),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );

  assign all_outs = {load_12bit_f1, load_14bit_f1, load_16bit_f1, load_8bit_f2, load_10bit_f2,
                     load_12bit_f2, frame_start, msg_start, msg_done, serial_idx, stale_f1,
                     stale_f2, load_err, underrun_cnt, busy};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected one-hot {wide, mid, narrow} strobe for a source
  function automatic logic [2:0] strobe_exp(input bit empty, input logic [1:0] w);
    if (empty) return 3'b000;
    if (w == 2'd1) return 3'b010;
    if (w == 2'd2) return 3'b100;
    return 3'b001;
  endfunction

  task automatic apply_reset();
    enable = 1'b0; frame_done = 1'b0; done_f1 = 1'b0; done_f2 = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_eq("reset_outputs", {6'd0, all_outs}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_underrun = 0; exp_idx = 0; exp_len = 16; exp_err = 1'b0;
  endtask

  // Called in the LOAD cycle; returns in the first WAIT_FRAME cycle
  task automatic run_frame(input bit f1e, input bit f2e, input logic [1:0] w1, input logic [1:0] w2,
                           input int d1, input int d2, input bit fmt, input bit spur);
    int c;
    int exp_fs;
    bit never1;
    bit never2;
    f1_empty = f1e; f2_empty = f2e; f1_width = w1; f2_width = w2; channel_format = fmt;
    tick();
    exp_underrun = exp_underrun + int'(f1e) + int'(f2e);
    if (exp_underrun > 255) exp_underrun = 255;
    check_eq("f1_strobe", {29'd0, load_16bit_f1, load_14bit_f1, load_12bit_f1}, {29'd0, strobe_exp(f1e, w1)});
    check_eq("f2_strobe", {29'd0, load_12bit_f2, load_10bit_f2, load_8bit_f2}, {29'd0, strobe_exp(f2e, w2)});
    check_eq("stale_f1_load", {31'd0, stale_f1}, {31'd0, f1e});
    check_eq("stale_f2_load", {31'd0, stale_f2}, {31'd0, f2e});
    check_eq("underrun_cnt", {24'd0, underrun_cnt}, exp_underrun);

    never1 = !f1e && (d1 > TMO);
    never2 = !f2e && (d2 > TMO);
    exp_fs = 1;
    if (!f1e && (d1 + 1 > exp_fs)) exp_fs = d1 + 1;
    if (!f2e && (d2 + 1 > exp_fs)) exp_fs = d2 + 1;
    if (never1 || never2) exp_fs = TMO + 1;

    c = 0;
    while (!frame_start && c < 400) begin
      done_f1 = (!f1e && c == d1) || (f1e && spur && c == 1);
      done_f2 = (!f2e && c == d2) || (f2e && spur && c == 1);
      tick();
      c = c + 1;
      if (c == 1) begin
        check_eq("strobe_width", {26'd0, load_12bit_f1, load_14bit_f1, load_16bit_f1,
                 load_8bit_f2, load_10bit_f2, load_12bit_f2}, 32'd0);
      end
    end
    done_f1 = 1'b0; done_f2 = 1'b0;
    check_eq("fs_latency", c, exp_fs);

    if (exp_idx == 0) exp_len = fmt ? 18 : 16;
    if (never1 || never2) exp_err = 1'b1;
    check_eq("msg_start", {31'd0, msg_start}, {31'd0, exp_idx == 0});
    check_eq("serial_idx_fs", {27'd0, serial_idx}, exp_idx);
    check_eq("load_err", {31'd0, load_err}, {31'd0, exp_err});
    check_eq("stale_f1_fs", {31'd0, stale_f1}, {31'd0, f1e | never1});
    check_eq("stale_f2_fs", {31'd0, stale_f2}, {31'd0, f2e | never2});
    check_eq("busy_fs", {31'd0, busy}, 32'd1);
    tick();
    check_eq("fs_width", {30'd0, frame_start, msg_start}, 32'd0);
  endtask

  // Completes the frame; returns in the next LOAD cycle (re-enabling after IDLE)
  task automatic finish_frame(input int gap, input bit en_after, input bit drop_early);
    bit last;
    if (drop_early) enable = 1'b0;
    repeat (gap) tick();
    frame_done = 1'b1;
    enable = en_after;
    tick();
    frame_done = 1'b0;
    last = (exp_idx == exp_len - 1);
    exp_idx = (last || !en_after) ? 0 : exp_idx + 1;
    check_eq("msg_done", {31'd0, msg_done}, {31'd0, last});
    check_eq("serial_idx_done", {27'd0, serial_idx}, exp_idx);
    check_eq("busy_done", {31'd0, busy}, {31'd0, en_after});
    if (!en_after) begin
      repeat ($urandom_range(0, 3)) tick();
      check_eq("idle_hold_busy", {31'd0, busy}, 32'd0);
      enable = 1'b1;
      tick();
    end
  endtask

  initial begin
    apply_reset();
    repeat (3) tick();
    check_eq("idle_hold", {6'd0, all_outs}, 32'd0);
    enable = 1'b1;
    tick();

    // Both sources loaded, done one cycle after the strobes
    run_frame(1'b0, 1'b0, 2'd1, 2'd2, 1, 1, 1'b0, 1'b0);
    finish_frame(0, 1'b1, 1'b0);

    // F2 starving: underrun counter climbs and saturates
    for (int i = 0; i < 300; i++) begin
      run_frame(1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(1, 3), 1, 1'b0, 1'($urandom_range(0, 1)));
      if (i == 0) check_eq("underrun_first", {24'd0, underrun_cnt}, 32'd1);
      finish_frame($urandom_range(0, 2), 1'b1, 1'b0);
    end
    check_eq("underrun_sat", {24'd0, underrun_cnt}, 32'd255);

    // F1 never answers: load timeout
    run_frame(1'b0, 1'b0, 2'd0, 2'd1, NEVER, 2, 1'b0, 1'b0);
    finish_frame(1, 1'b1, 1'b0);

    // Enhanced message, format flipped mid-message, then the following message
    apply_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      run_frame(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                1, $urandom_range(1, 2), (i < 5), 1'b0);
      finish_frame($urandom_range(0, 3), 1'b1, 1'b0);
    end

    // Enable dropped mid-frame at serial_idx 7
    for (int k = 0; k < 40 && exp_idx != 7; k++) begin
      run_frame(1'b0, 1'b0, 2'd0, 2'd0, 1, 1, 1'b0, 1'b0);
      finish_frame(0, 1'b1, 1'b0);
    end
    check_eq("reached_idx7", exp_idx, 32'd7);
    run_frame(1'b0, 1'b0, 2'd2, 2'd0, 2, 1, 1'b1, 1'b0);
    finish_frame(2, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 2'd0, 2'd0, 1, 1, 1'b0, 1'b0);
    finish_frame(0, 1'b1, 1'b0);

    // Randomized frames
    for (int i = 0; i < 150; i++) begin
      bit en_after;
      en_after = ($urandom_range(0, 15) != 0);
      run_frame(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(1, 4), $urandom_range(1, 4),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_frame($urandom_range(0, 4), en_after, !en_after && ($urandom_range(0, 1) == 1));
    end

    // Async reset in WAIT_FRAME after a timed-out load
    run_frame(1'b0, 1'b0, 2'd1, 2'd1, NEVER, NEVER, 1'b0, 1'b0);
    check_eq("err_before_reset", {31'd0, load_err}, 32'd1);
    apply_reset();
    tick();
    check_eq("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sent_tx_frame_sched.md
Name: sent_tx_frame_sched

Overview:
- Per-frame scheduler for the SENT transmitter, clocked in the clk (tick-generation) domain. It sits between the F1/F2 async FIFOs' read-side flags, sent_tx_data_reg and sent_tx_control.
- Each frame it decides which fast-channel sources are reloaded from their FIFOs, sequences load → frame start → frame done, and tracks the slow-channel (serial/enhanced) bit position across frames.
- It also flags stale data and load timeouts.

Parameters:
- LOAD_TIMEOUT, 255: max cycles to wait for a load done before aborting the load; range 1..255.
- SHORT_LEN, 16: frames per short-serial message.
- ENH_LEN, 18: frames per enhanced-serial message.

Ports:
- clk  in  1  transmitter clock
- reset_n  in  1  reset; asynchronous, active-low (already decided)
- enable  in  1  run scheduling
- channel_format  in  1  0 short serial, 1 enhanced
- f1_width  in  2  F1 load width: 0=12, 1=14, 2=16 bit; 3 treated as 0
- f2_width  in  2  F2 load width: 0=8, 1=10, 2=12 bit; 3 treated as 0
- f1_empty  in  1  F1 FIFO read_empty
- f2_empty  in  1  F2 FIFO read_empty
- done_f1  in  1  F1 load complete pulse from data reg
- done_f2  in  1  F2 load complete pulse from data reg
- frame_done  in  1  frame transmission complete pulse from control
- load_12bit_f1, load_14bit_f1, load_16bit_f1  out  1 each  one-hot F1 load strobes
- load_8bit_f2, load_10bit_f2, load_12bit_f2  out  1 each  one-hot F2 load strobes
- frame_start  out  1  start-frame pulse to control
- serial_idx  out  5  slow-channel bit index of the current frame
- msg_start  out  1  pulse with frame_start when serial_idx==0
- msg_done  out  1  pulse on frame_done of the last frame of a message
- stale_f1, stale_f2  out  1 each  current frame reuses previous data
- load_err  out  1  sticky: a load timed out; cleared only by reset
- underrun_cnt  out  8  count of stale source-frames, saturating at 255
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal format latch 0, timeout counter 0.
- All outputs are registered. Load and start strobes are exactly 1 cycle wide.
- State machine: IDLE → LOAD → WAIT_LOAD → START → WAIT_FRAME.
- IDLE:
  - Stay while enable=0.
  - On enable=1, go to LOAD next cycle.
- LOAD (1 cycle):
  - For each source with empty=0, assert the strobe selected by its width and set pend_fx=1.
  - For each source with empty=1, assert no strobe, set stale_fx=1 and increment underrun_cnt; two empties in the same cycle add 2 (saturating at 255).
  - A non-empty source clears its stale flag.
  - Go to WAIT_LOAD.
- WAIT_LOAD:
  - done_fx clears pend_fx; a done arriving in the LOAD cycle itself is also accepted.
  - Leave when both pend flags are 0; with both FIFOs empty this takes 1 cycle.
  - The timeout counter increments each cycle. At LOAD_TIMEOUT: set load_err, set stale for every still-pending source, clear pend, go to START.
  - Any done_fx without a matching pend is ignored.
- START (1 cycle):
  - Assert frame_start.
  - If serial_idx==0, assert msg_start and latch channel_format; the message length is ENH_LEN when latched=1, else SHORT_LEN.
  - Go to WAIT_FRAME.
- WAIT_FRAME:
  - On frame_done: if serial_idx==len-1, pulse msg_done and set serial_idx to 0; else increment serial_idx.
  - Then go to LOAD if enable=1, else IDLE.
  - No timeout in this state.
- enable deassert:
  - The current frame always completes.
  - On the return to IDLE, serial_idx resets to 0, so the message is aborted without msg_done.
  - Changing channel_format mid-message has no effect until the next msg_start.
- Width changes take effect at the next LOAD only.
- Latency: enable rise at cycle 0 → first load strobe at cycle 2 → frame_start at earliest cycle 4 (done in cycle 3).
- Async reset mid-frame returns to IDLE immediately and clears everything, including load_err.

Test Plan:
- Both FIFOs non-empty, f1_width=1, f2_width=2, done responses 1 cycle after strobe → load_14bit_f1 and load_12bit_f2 high for 1 cycle, frame_start 2 cycles later, stale flags 0.
- f2_empty=1, f1 non-empty → only the F1 strobe fires; stale_f2=1, underrun_cnt=1. After 300 such frames, underrun_cnt=255.
- done_f1 never returned, LOAD_TIMEOUT=255 → frame_start 256 cycles after WAIT_LOAD entry, load_err=1, stale_f1=1.
- channel_format=1, 18 frame_done pulses → serial_idx counts 0..17, msg_done on the 18th, msg_start on the 1st and 19th frames. Flipping the format at frame 5 leaves the length at 18.
- enable dropped at serial_idx=7 mid-frame → frame_done still accepted, then IDLE with serial_idx=0 and no msg_done. Re-enable → msg_start on the next frame_start.
- reset_n pulsed low in WAIT_FRAME → all outputs 0 asynchronously, busy=0, load_err=0.
